// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode map, program-memory NOP default
// and the program-memory controller state type.
package cpu_pkg;

    localparam logic [3:0] OP_LDA  = 4'b0000;
    localparam logic [3:0] OP_LDB  = 4'b0001;
    localparam logic [3:0] OP_LDO  = 4'b0010;
    localparam logic [3:0] OP_LDSA = 4'b0011;
    localparam logic [3:0] OP_LDSB = 4'b0100;
    localparam logic [3:0] OP_LSH  = 4'b0101;
    localparam logic [3:0] OP_RSH  = 4'b0110;
    localparam logic [3:0] OP_CLR  = 4'b0111;
    localparam logic [3:0] OP_SNZA = 4'b1000;
    localparam logic [3:0] OP_ADD  = 4'b1010;
    localparam logic [3:0] OP_SUB  = 4'b1011;
    localparam logic [3:0] OP_XOR  = 4'b1110;

    localparam logic [3:0] PM_NOP_OPCODE = OP_CLR;

    typedef enum logic [1:0] {
        PM_EMPTY   = 2'd0,
        PM_LOADING = 2'd1,
        PM_READY   = 2'd2
    } pm_state_t;

endpackage

// File: rtl/program_memory_if.sv
// Load and fetch ports of the program memory.
// master drives loads/fetches, slave is the memory.
interface program_memory_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 4
);
    logic                  load_start;
    logic                  load_valid;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  load_ready;
    logic                  load_end;
    logic                  fetch_req;
    logic [ADDR_WIDTH-1:0] fetch_addr;
    logic                  fetch_ready;
    logic                  fetch_valid;
    logic [DATA_WIDTH-1:0] fetch_data;
    logic [ADDR_WIDTH:0]   prog_len;
    logic                  full;

    modport master (
        output load_start, load_valid, load_data, load_end,
        output fetch_req, fetch_addr,
        input  load_ready, fetch_ready, fetch_valid, fetch_data,
        input  prog_len, full
    );

    modport slave (
        input  load_start, load_valid, load_data, load_end,
        input  fetch_req, fetch_addr,
        output load_ready, fetch_ready, fetch_valid, fetch_data,
        output prog_len, full
    );
endinterface

// File: rtl/program_memory_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port.
// No reset so it maps onto block or distributed RAM.
module pm_ram #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 4,
    parameter int DEPTH      = 256
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i[IW-1:0]] <= wdata_i;
        end
        if (re_i) begin
            rdata_o <= mem[raddr_i[IW-1:0]];
        end
    end

    // Upper address bits only matter for the range check in the parent.
    if (ADDR_WIDTH > IW) begin : g_hi
        logic unused_hi;
        assign unused_hi = ^{waddr_i[ADDR_WIDTH-1:IW],
                             raddr_i[ADDR_WIDTH-1:IW]};
    end
endmodule

// File: rtl/program_memory.sv
// Loadable instruction store with streamed load port and a
// one-cycle fetch port; out-of-program addresses read as NOP.
module program_memory
    import cpu_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DATA_WIDTH = 4,
    parameter int                    DEPTH      = 256,
    parameter logic [DATA_WIDTH-1:0] NOP_OPCODE = PM_NOP_OPCODE
) (
    input logic             clk,
    input logic             rst,
    program_memory_if.slave bus
);
    localparam logic [ADDR_WIDTH:0] LEN_DEPTH = (ADDR_WIDTH+1)'(DEPTH);

    pm_state_t             state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   prog_len_q, prog_len_d;
    logic                  valid_q, hit_q, hit_d;
    logic                  load_ready, fetch_ready, full;
    logic                  wr_en, rd_en;
    logic [DATA_WIDTH-1:0] ram_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PM_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // load_start wins over load_end and restarts from any state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            PM_EMPTY:   state_d = PM_EMPTY;
            PM_LOADING: if (bus.load_end) state_d = PM_READY;
            PM_READY:   state_d = PM_READY;
            default:    state_d = PM_EMPTY;
        endcase
        if (bus.load_start) begin
            state_d = PM_LOADING;
        end
    end

    always_comb begin
        full        = (prog_len_q == LEN_DEPTH);
        load_ready  = (state_q == PM_LOADING) && !full && !bus.load_start;
        fetch_ready = (state_q == PM_READY);
    end

    assign wr_en = bus.load_valid && load_ready;
    assign rd_en = bus.fetch_req && fetch_ready;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        prog_len_d = prog_len_q;
        if (bus.load_start) begin
            wr_ptr_d   = '0;
            prog_len_d = '0;
        end else if (wr_en) begin
            wr_ptr_d   = wr_ptr_q + ADDR_WIDTH'(1);
            prog_len_d = prog_len_q + (ADDR_WIDTH+1)'(1);
        end
        hit_d = hit_q;
        if (rd_en) begin
            hit_d = ({1'b0, bus.fetch_addr} < prog_len_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            prog_len_q <= '0;
            valid_q    <= 1'b0;
            hit_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            prog_len_q <= prog_len_d;
            valid_q    <= rd_en;
            hit_q      <= hit_d;
        end
    end

    pm_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q),
        .wdata_i (bus.load_data),
        .re_i    (rd_en),
        .raddr_i (bus.fetch_addr),
        .rdata_o (ram_rdata)
    );

    // RAM output and hit flag both hold between fetches, so data holds too.
    assign bus.fetch_data  = hit_q ? ram_rdata : NOP_OPCODE;
    assign bus.fetch_valid = valid_q;
    assign bus.load_ready  = load_ready;
    assign bus.fetch_ready = fetch_ready;
    assign bus.prog_len    = prog_len_q;
    assign bus.full        = full;
endmodule

// File: tb/tb_program_memory.sv
// Directed bench for program_memory: default build plus a
// DEPTH=4 build sharing clock and reset.
module tb_program_memory;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nchk = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    program_memory_if #(.ADDR_WIDTH(8), .DATA_WIDTH(4)) ia ();
    program_memory_if #(.ADDR_WIDTH(8), .DATA_WIDTH(4)) ib ();

    program_memory #(
        .ADDR_WIDTH(8), .DATA_WIDTH(4), .DEPTH(256), .NOP_OPCODE(4'b0111)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (ia)
    );

    program_memory #(
        .ADDR_WIDTH(8), .DATA_WIDTH(4), .DEPTH(4), .NOP_OPCODE(4'b0111)
    ) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (ib)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [3:0] wa [8] = '{4'b0000, 4'b0001, 4'b1010, 4'b0010,
                           4'b1011, 4'b0010, 4'b1110, 4'b0010};
    logic [3:0] wb [6] = '{4'b1010, 4'b1011, 4'b1110, 4'b0001,
                           4'b0110, 4'b0011};
    logic [3:0] wc [3] = '{4'b0101, 4'b0110, 4'b1000};

    initial begin
        ia.load_start = 0; ia.load_valid = 0; ia.load_data = '0;
        ia.load_end = 0; ia.fetch_req = 0; ia.fetch_addr = '0;
        ib.load_start = 0; ib.load_valid = 0; ib.load_data = '0;
        ib.load_end = 0; ib.fetch_req = 0; ib.fetch_addr = '0;
        tick;
        tick;
        rst = 0;

        // 1: fetch while empty is dropped
        ia.fetch_req = 1; ia.fetch_addr = 0;
        #1;
        chk("rst_fetch_ready", 32'(ia.fetch_ready), 0);
        chk("rst_load_ready", 32'(ia.load_ready), 0);
        chk("rst_full", 32'(ia.full), 0);
        tick;
        chk("empty_valid", 32'(ia.fetch_valid), 0);
        chk("empty_data", 32'(ia.fetch_data), 32'h7);
        chk("empty_len", 32'(ia.prog_len), 0);
        ia.fetch_req = 0;

        // 2: load 8 words, fetch 0..9 back-to-back
        ia.load_start = 1;
        tick;
        ia.load_start = 0;
        for (int i = 0; i < 8; i++) begin
            ia.load_valid = 1; ia.load_data = wa[i];
            #1;
            chk($sformatf("ld_ready%0d", i), 32'(ia.load_ready), 1);
            tick;
        end
        ia.load_valid = 0;
        ia.load_end = 1;
        tick;
        ia.load_end = 0;
        chk("len8", 32'(ia.prog_len), 8);
        chk("ready_fetch", 32'(ia.fetch_ready), 1);
        for (int i = 0; i < 10; i++) begin
            ia.fetch_req = 1; ia.fetch_addr = 8'(i);
            tick;
            chk($sformatf("f_valid%0d", i), 32'(ia.fetch_valid), 1);
            chk($sformatf("f_data%0d", i), 32'(ia.fetch_data),
                (i < 8) ? 32'(wa[i]) : 32'h7);
        end
        ia.fetch_req = 0;
        tick;
        chk("idle_valid", 32'(ia.fetch_valid), 0);
        chk("idle_hold", 32'(ia.fetch_data), 32'h7);
        ia.fetch_req = 1; ia.fetch_addr = 6;
        tick;
        ia.fetch_req = 0;
        tick;
        chk("hold_valid", 32'(ia.fetch_valid), 0);
        chk("hold_data", 32'(ia.fetch_data), 32'he);

        // 3: DEPTH=4 build stops at full
        ib.load_start = 1;
        tick;
        ib.load_start = 0;
        for (int i = 0; i < 6; i++) begin
            ib.load_valid = 1; ib.load_data = wb[i];
            #1;
            chk($sformatf("d4_ready%0d", i), 32'(ib.load_ready),
                (i < 4) ? 1 : 0);
            tick;
        end
        ib.load_valid = 0;
        chk("d4_len", 32'(ib.prog_len), 4);
        chk("d4_full", 32'(ib.full), 1);
        ib.load_end = 1;
        tick;
        ib.load_end = 0;
        ib.fetch_req = 1; ib.fetch_addr = 3;
        tick;
        chk("d4_f3", 32'(ib.fetch_data), 32'h1);
        ib.fetch_addr = 4;
        tick;
        chk("d4_f4", 32'(ib.fetch_data), 32'h7);
        ib.fetch_addr = 255;
        tick;
        chk("d4_f255", 32'(ib.fetch_data), 32'h7);
        ib.fetch_req = 0;

        // 4: load_start with fetch in READY
        ia.load_start = 1; ia.fetch_req = 1; ia.fetch_addr = 2;
        tick;
        ia.load_start = 0; ia.fetch_req = 0;
        #1;
        chk("ls_f_valid", 32'(ia.fetch_valid), 1);
        chk("ls_f_data", 32'(ia.fetch_data), 32'ha);
        chk("ls_f_ready", 32'(ia.fetch_ready), 0);
        chk("ls_len", 32'(ia.prog_len), 0);
        chk("ls_ld_ready", 32'(ia.load_ready), 1);

        // 5: load_end with the 3rd accepted word
        for (int i = 0; i < 3; i++) begin
            ia.load_valid = 1; ia.load_data = wc[i];
            ia.load_end = (i == 2);
            tick;
        end
        ia.load_valid = 0; ia.load_end = 0;
        chk("le_len", 32'(ia.prog_len), 3);
        chk("le_ready", 32'(ia.fetch_ready), 1);
        ia.fetch_req = 1; ia.fetch_addr = 2;
        tick;
        chk("le_f2", 32'(ia.fetch_data), 32'h8);
        ia.fetch_addr = 3;
        tick;
        chk("le_f3", 32'(ia.fetch_data), 32'h7);
        ia.fetch_req = 0;

        // 6: reset mid-load, then restart
        ia.load_start = 1;
        tick;
        ia.load_start = 0;
        ia.load_valid = 1; ia.load_data = 4'b0011;
        tick;
        ia.load_data = 4'b0100;
        tick;
        chk("pre_rst_len", 32'(ia.prog_len), 2);
        rst = 1;
        tick;
        rst = 0; ia.load_valid = 0;
        #1;
        chk("mid_rst_len", 32'(ia.prog_len), 0);
        chk("mid_rst_ld_ready", 32'(ia.load_ready), 0);
        chk("mid_rst_valid", 32'(ia.fetch_valid), 0);
        chk("mid_rst_data", 32'(ia.fetch_data), 32'h7);
        ia.load_start = 1;
        tick;
        ia.load_start = 0;
        ia.load_valid = 1; ia.load_data = 4'b1110; ia.load_end = 1;
        tick;
        ia.load_valid = 0; ia.load_end = 0;
        chk("rl_len", 32'(ia.prog_len), 1);
        ia.fetch_req = 1; ia.fetch_addr = 0;
        tick;
        chk("rl_f0", 32'(ia.fetch_data), 32'he);
        ia.fetch_addr = 1;
        tick;
        chk("rl_f1", 32'(ia.fetch_data), 32'h7);

        // reset with a fetch in flight suppresses fetch_valid
        ia.fetch_addr = 0; rst = 1;
        tick;
        rst = 0; ia.fetch_req = 0;
        #1;
        chk("rf_valid", 32'(ia.fetch_valid), 0);
        chk("rf_data", 32'(ia.fetch_data), 32'h7);
        chk("rf_ready", 32'(ia.fetch_ready), 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
